// File: rtl/prefix_scheduler.sv
// Dispatches ruler-prefix jobs to a pool of assembly engines and collects their results.
// Optional RESULT_FILTER_EN: drop results longer than the best accepted ruler length.
module prefix_scheduler #(
  parameter int NUM_ENGINES  = 2,
  parameter int NUMPOSITIONS = 5,
  parameter int VALW         = 9,
  parameter int RST_CYCLES   = 2,
  localparam int RW = (NUMPOSITIONS + 1) * VALW
) (
  input  logic                      FXCLK,
  input  logic                      RESET_IN,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [RW-1:0]             job_prefix,
  input  logic                      abort,
  output logic [NUM_ENGINES-1:0]    eng_reset,
  output logic [NUM_ENGINES*RW-1:0] eng_firstvalues,
  input  logic [NUM_ENGINES-1:0]    eng_done,
  input  logic [NUM_ENGINES*RW-1:0] eng_marks,
  input  logic [NUM_ENGINES*6-1:0]  eng_numresults,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [RW-1:0]             res_marks,
  output logic [2:0]                res_engine,
  output logic [5:0]                res_count,
  output logic [VALW-1:0]           best_len,
  output logic [3:0]                busy_cnt,
  output logic                      all_idle,
  output logic [2*NUM_ENGINES-1:0]  o_dbg_state
);
  // Handshakes: a job or a result moves on a rising edge where valid and ready are both
  // high; once res_valid is raised its payload holds until res_ready (or abort/reset).
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_REPORT} eng_state_t;

  eng_state_t      r_state [NUM_ENGINES];
  eng_state_t      w_nxt   [NUM_ENGINES];
  logic [7:0]      r_ldcnt [NUM_ENGINES];
  logic [RW-1:0]   r_fv    [NUM_ENGINES];
  logic [RW-1:0]   r_hmarks[NUM_ENGINES];
  logic [5:0]      r_hcnt  [NUM_ENGINES];
  logic [2:0]      r_jp, r_rp, r_lock_eng;
  logic            r_lock;
  logic [VALW-1:0] r_best;

  logic [7:0]      w_idle_v, w_elig_v, w_filt_v;
  logic [2:0]      w_jsel, w_pick, w_gnt;
  logic            w_jfound, w_pick_ok, w_has, w_accept, w_xfer;
  logic [RW-1:0]   w_gnt_marks;
  logic [5:0]      w_gnt_cnt;
  logic [VALW-1:0] w_gnt_len;
  logic [3:0]      w_busy;

  function automatic logic [2:0] rr_idx(input logic [2:0] base, input int k);
    return 3'((int'(base) + k) % NUM_ENGINES);
  endfunction

  always_comb begin
    w_idle_v = '0;
    w_elig_v = '0;
    w_filt_v = '0;
    w_busy   = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      w_idle_v[i] = (r_state[i] == S_IDLE);
`ifdef RESULT_FILTER_EN
      w_filt_v[i] = (r_state[i] == S_REPORT) && (r_hmarks[i][RW-1 -: VALW] > r_best);
`endif
      w_elig_v[i] = (r_state[i] == S_REPORT) && !w_filt_v[i];
      w_busy      = w_busy + {3'b000, !w_idle_v[i]};
    end
  end

  // Round-robin searches for the job target and the next result to present.
  always_comb begin
    w_jsel    = '0;
    w_jfound  = 1'b0;
    w_pick    = '0;
    w_pick_ok = 1'b0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (!w_jfound && w_idle_v[rr_idx(r_jp, k)]) begin
        w_jsel   = rr_idx(r_jp, k);
        w_jfound = 1'b1;
      end
      if (!w_pick_ok && w_elig_v[rr_idx(r_rp, k)]) begin
        w_pick    = rr_idx(r_rp, k);
        w_pick_ok = 1'b1;
      end
    end
  end

  assign w_gnt = r_lock ? r_lock_eng : w_pick;
  assign w_has = r_lock || w_pick_ok;

  always_comb begin
    w_gnt_marks = '0;
    w_gnt_cnt   = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (w_gnt == 3'(i)) begin
        w_gnt_marks = r_hmarks[i];
        w_gnt_cnt   = r_hcnt[i];
      end
    end
  end
  assign w_gnt_len = w_gnt_marks[RW-1 -: VALW];

  assign res_valid  = !RESET_IN && !abort && w_has;
  assign job_ready  = !RESET_IN && !abort && w_jfound;
  assign w_accept   = job_valid && job_ready;
  assign w_xfer     = res_valid && res_ready;
  assign res_marks  = res_valid ? w_gnt_marks : '0;
  assign res_engine = res_valid ? w_gnt : 3'd0;
  assign res_count  = res_valid ? w_gnt_cnt : 6'd0;
  assign best_len   = r_best;
  assign busy_cnt   = w_busy;
  assign all_idle   = (w_busy == 4'd0);

  always_comb begin
    eng_reset       = '0;
    eng_firstvalues = '0;
    o_dbg_state     = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      eng_reset[i]                = (r_state[i] != S_RUN);
      eng_firstvalues[i*RW +: RW] = r_fv[i];
      o_dbg_state[2*i +: 2]       = r_state[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENGINES; i++) begin
      w_nxt[i] = r_state[i];
      case (r_state[i])
        S_IDLE:   if (w_accept && w_jsel == 3'(i)) w_nxt[i] = S_LOAD;
        S_LOAD:   if (r_ldcnt[i] == 8'd0) w_nxt[i] = S_RUN;
        S_RUN:    if (eng_done[i])
                    w_nxt[i] = (eng_numresults[i*6 +: 6] == 6'd0) ? S_IDLE : S_REPORT;
        S_REPORT: if ((w_xfer && w_gnt == 3'(i)) || w_filt_v[i]) w_nxt[i] = S_IDLE;
        default:  w_nxt[i] = S_IDLE;
      endcase
      if (abort) w_nxt[i] = S_IDLE;
    end
  end

  always_ff @(posedge FXCLK) begin
    if (RESET_IN) begin
      r_jp       <= '0;
      r_rp       <= '0;
      r_lock     <= 1'b0;
      r_lock_eng <= '0;
      r_best     <= '1;
      for (int i = 0; i < NUM_ENGINES; i++) begin
        r_state[i]  <= S_IDLE;
        r_ldcnt[i]  <= '0;
        r_fv[i]     <= '0;
        r_hmarks[i] <= '0;
        r_hcnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        r_state[i] <= w_nxt[i];
        if (abort) begin
          r_hmarks[i] <= '0;
          r_hcnt[i]   <= '0;
        end else begin
          if (w_accept && w_jsel == 3'(i)) begin
            r_fv[i]    <= job_prefix;
            r_ldcnt[i] <= 8'(RST_CYCLES - 1);
          end else if (r_state[i] == S_LOAD && r_ldcnt[i] != 8'd0) begin
            r_ldcnt[i] <= r_ldcnt[i] - 8'd1;
          end
          if (r_state[i] == S_RUN && eng_done[i] && eng_numresults[i*6 +: 6] != 6'd0) begin
            r_hmarks[i] <= eng_marks[i*RW +: RW];
            r_hcnt[i]   <= eng_numresults[i*6 +: 6];
          end
        end
      end
      // A stalled offer is pinned so a newly reporting engine cannot displace it.
      if (abort) begin
        r_lock <= 1'b0;
      end else begin
        r_lock     <= res_valid && !res_ready;
        r_lock_eng <= w_gnt;
      end
      if (w_xfer) begin
        r_rp <= rr_idx(w_gnt, 1);
        if (w_gnt_len < r_best) r_best <= w_gnt_len;
      end
      if (w_accept) r_jp <= rr_idx(w_jsel, 1);
    end
  end
endmodule

// File: tb/tb_prefix_scheduler.sv
// Self-checking bench for prefix_scheduler: directed vector table, hand-written corner
// sequences and a randomized run checked against a job/result-level reference model.
module tb_prefix_scheduler;
  localparam int N    = 2;
  localparam int VALW = 9;
  localparam int RST  = 2;
  localparam int RW   = 6 * VALW;
`ifdef RESULT_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif
  localparam logic [RW-1:0] PA = RW'(1) << VALW;
  localparam logic [RW-1:0] PC = RW'(3) << (2 * VALW);

  logic FXCLK = 1'b0;
  logic RESET_IN, job_valid, job_ready, abort, res_valid, res_ready, all_idle;
  logic [RW-1:0]   job_prefix, res_marks;
  logic [N-1:0]    eng_reset, eng_done;
  logic [N*RW-1:0] eng_firstvalues, eng_marks;
  logic [N*6-1:0]  eng_numresults;
  logic [2:0]      res_engine;
  logic [5:0]      res_count;
  logic [VALW-1:0] best_len;
  logic [3:0]      busy_cnt;
  logic [2*N-1:0]  dbg_state;

  prefix_scheduler #(.NUM_ENGINES(N), .NUMPOSITIONS(5), .VALW(VALW), .RST_CYCLES(RST)) dut (
    .FXCLK(FXCLK), .RESET_IN(RESET_IN), .job_valid(job_valid), .job_ready(job_ready),
    .job_prefix(job_prefix), .abort(abort), .eng_reset(eng_reset),
    .eng_firstvalues(eng_firstvalues), .eng_done(eng_done), .eng_marks(eng_marks),
    .eng_numresults(eng_numresults), .res_valid(res_valid), .res_ready(res_ready),
    .res_marks(res_marks), .res_engine(res_engine), .res_count(res_count),
    .best_len(best_len), .busy_cnt(busy_cnt), .all_idle(all_idle), .o_dbg_state(dbg_state)
  );

  // Clock/reset block
  always #5 FXCLK = ~FXCLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic clear_inputs();
    job_valid = 1'b0; job_prefix = '0; abort = 1'b0; eng_done = '0;
    eng_marks = '0; eng_numresults = '0; res_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge FXCLK);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    RESET_IN = 1'b1;
    repeat (2) @(posedge FXCLK);
    #1;
    RESET_IN = 1'b0;
  endtask

  task automatic set_len(input int e, input int len);
    eng_marks[e*RW + RW - VALW +: VALW] = VALW'(len);
  endtask

  // Two jobs accepted back to back, then wait until both engines are running.
  task automatic start_two();
    job_valid = 1'b1; job_prefix = PA;
    tick();
    tick();
    job_valid = 1'b0;
    tick();
    tick();
  endtask

  // Vector table
  typedef struct {
    logic rst, jv, rr;
    logic [1:0] done;
    logic ejr, evalid;
    logic [1:0] ereset;
    logic [3:0] ebusy;
    logic [RW-1:0] efv0;
  } vec_t;
  vec_t tbl[10];

  function automatic vec_t mkv(logic rst, logic jv, logic rr, logic [1:0] done, logic ejr,
                               logic ev, logic [1:0] er, logic [3:0] eb, logic [RW-1:0] fv);
    vec_t v;
    v.rst = rst; v.jv = jv; v.rr = rr; v.done = done; v.ejr = ejr;
    v.evalid = ev; v.ereset = er; v.ebusy = eb; v.efv0 = fv;
    return v;
  endfunction

  // Reference model: per engine "job held", remaining reset cycles, pending result.
  bit              m_busy[N];
  int              m_load[N];
  bit              m_has[N];
  logic [RW-1:0]   m_hm[N];
  logic [5:0]      m_hc[N];
  logic [RW-1:0]   m_fv[N];
  int              m_jp, m_rp, m_offer;
  logic [VALW-1:0] m_best;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_load[i] = 0; m_has[i] = 0; m_hm[i] = '0; m_hc[i] = '0; m_fv[i] = '0;
    end
    m_jp = 0; m_rp = 0; m_offer = -1; m_best = '1;
  endtask

  function automatic bit m_filt(input int e);
    return FILT_ON && m_has[e] && (m_hm[e][RW-1 -: VALW] > m_best);
  endfunction

  // Scoreboard of expected result lengths in offer order
  logic [VALW-1:0] exp_q[$];

  initial begin
    int off, sel, nfree;
    bit ejr, ev, xfer;
    logic [63:0] rnd;
    RESET_IN = 1'b1;
    clear_inputs();

    tbl[0] = mkv(1, 1, 0, 2'b00, 0, 0, 2'b11, 0, '0);
    tbl[1] = mkv(0, 1, 0, 2'b00, 1, 0, 2'b11, 0, '0);
    tbl[2] = mkv(0, 1, 0, 2'b00, 1, 0, 2'b11, 1, PA);
    tbl[3] = mkv(0, 1, 0, 2'b00, 0, 0, 2'b11, 2, PA);
    tbl[4] = mkv(0, 1, 0, 2'b00, 0, 0, 2'b10, 2, PA);
    tbl[5] = mkv(0, 1, 0, 2'b01, 0, 0, 2'b00, 2, PA);
    tbl[6] = mkv(0, 1, 0, 2'b00, 0, 1, 2'b01, 2, PA);
    tbl[7] = mkv(0, 1, 1, 2'b00, 0, 1, 2'b01, 2, PA);
    tbl[8] = mkv(0, 1, 0, 2'b00, 1, 0, 2'b01, 1, PA);
    tbl[9] = mkv(0, 0, 0, 2'b00, 0, 0, 2'b01, 2, PC);

    do_reset();
    set_len(0, 20);
    eng_numresults = {6'd3, 6'd3};
    for (int r = 0; r < 10; r++) begin
      RESET_IN = tbl[r].rst; job_valid = tbl[r].jv; res_ready = tbl[r].rr;
      eng_done = tbl[r].done; job_prefix = (r >= 8) ? PC : PA;
      @(negedge FXCLK);
      chk($sformatf("tbl%0d_job_ready", r), 64'(job_ready), 64'(tbl[r].ejr));
      chk($sformatf("tbl%0d_res_valid", r), 64'(res_valid), 64'(tbl[r].evalid));
      chk($sformatf("tbl%0d_eng_reset", r), 64'(eng_reset), 64'(tbl[r].ereset));
      chk($sformatf("tbl%0d_busy_cnt", r), 64'(busy_cnt), 64'(tbl[r].ebusy));
      chk($sformatf("tbl%0d_fv0", r), 64'(eng_firstvalues[RW-1:0]), 64'(tbl[r].efv0));
      tick();
    end
    chk("tbl_best_len", 64'(best_len), 64'd20);

    // Both engines finish together with equal lengths
    do_reset();
    start_two();
    eng_done = 2'b11; eng_numresults = {6'd2, 6'd1};
    set_len(0, 17); set_len(1, 17); eng_marks[0 +: VALW] = 9'd4; res_ready = 1'b1;
    tick();
    eng_done = 2'b00;
    @(negedge FXCLK);
    chk("dual_first_valid", 64'(res_valid), 64'd1);
    chk("dual_first_engine", 64'(res_engine), 64'd0);
    chk("dual_first_marks", 64'(res_marks), 64'(eng_marks[RW-1:0]));
    chk("dual_first_count", 64'(res_count), 64'd1);
    tick();
    @(negedge FXCLK);
    chk("dual_second_valid", 64'(res_valid), 64'd1);
    chk("dual_second_engine", 64'(res_engine), 64'd1);
    chk("dual_second_count", 64'(res_count), 64'd2);
    tick();
    @(negedge FXCLK);
    chk("dual_after_valid", 64'(res_valid), 64'd0);
    chk("dual_best_len", 64'(best_len), 64'd17);
    chk("dual_all_idle", 64'(all_idle), 64'd1);

    // Done with zero results
    do_reset();
    job_valid = 1'b1; job_prefix = PA;
    tick();
    job_valid = 1'b0;
    tick(); tick();
    eng_done = 2'b01; eng_numresults = '0;
    @(negedge FXCLK);
    chk("zero_busy_before", 64'(busy_cnt), 64'd1);
    tick();
    eng_done = 2'b00;
    @(negedge FXCLK);
    chk("zero_res_valid", 64'(res_valid), 64'd0);
    chk("zero_busy_after", 64'(busy_cnt), 64'd0);
    chk("zero_eng_reset", 64'(eng_reset[0]), 64'd1);

    // Longer result after best_len is established
    do_reset();
    start_two();
    eng_done = 2'b01; eng_numresults = {6'd1, 6'd1}; set_len(0, 11); res_ready = 1'b1;
    tick();
    eng_done = 2'b00;
    tick();
    @(negedge FXCLK);
    chk("filt_best_11", 64'(best_len), 64'd11);
    res_ready = 1'b0; eng_done = 2'b10; set_len(1, 12);
    tick();
    eng_done = 2'b00;
    @(negedge FXCLK);
`ifdef RESULT_FILTER_EN
    chk("filt_on_valid", 64'(res_valid), 64'd0);
    tick();
    @(negedge FXCLK);
    chk("filt_on_busy", 64'(busy_cnt), 64'd0);
`else
    chk("filt_off_valid", 64'(res_valid), 64'd1);
    chk("filt_off_engine", 64'(res_engine), 64'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    @(negedge FXCLK);
    chk("filt_off_busy", 64'(busy_cnt), 64'd0);
`endif
    chk("filt_best_kept", 64'(best_len), 64'd11);

    // Abort while a result is stalled and another engine runs
    do_reset();
    start_two();
    eng_done = 2'b01; eng_numresults = {6'd1, 6'd1}; set_len(0, 30); res_ready = 1'b0;
    tick();
    eng_done = 2'b00;
    @(negedge FXCLK);
    chk("abort_pre_valid", 64'(res_valid), 64'd1);
    chk("abort_pre_busy", 64'(busy_cnt), 64'd2);
    tick();
    abort = 1'b1; res_ready = 1'b1; job_valid = 1'b1;
    @(negedge FXCLK);
    chk("abort_cyc_valid", 64'(res_valid), 64'd0);
    chk("abort_cyc_job_ready", 64'(job_ready), 64'd0);
    tick();
    abort = 1'b0; res_ready = 1'b0; job_valid = 1'b0;
    @(negedge FXCLK);
    chk("abort_all_idle", 64'(all_idle), 64'd1);
    chk("abort_res_valid", 64'(res_valid), 64'd0);
    chk("abort_best_len", 64'(best_len), 64'h1ff);

    // Randomized run against the reference model
    do_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      RESET_IN   = ($urandom_range(0, 199) == 0);
      abort      = ($urandom_range(0, 49) == 0);
      job_valid  = ($urandom_range(0, 1) == 1);
      rnd        = {$urandom, $urandom};
      job_prefix = rnd[RW-1:0];
      res_ready  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        rnd = {$urandom, $urandom};
        eng_marks[i*RW +: RW] = rnd[RW-1:0];
        set_len(i, int'($urandom_range(5, 40)));
        eng_done[i] = ($urandom_range(0, 2) == 0);
        eng_numresults[i*6 +: 6] = 6'($urandom_range(0, 3));
      end

      nfree = 0;
      for (int i = 0; i < N; i++) if (!m_busy[i]) nfree++;
      ejr = !RESET_IN && !abort && (nfree > 0);
      off = -1;
      if (!RESET_IN && !abort) begin
        if (m_offer >= 0) off = m_offer;
        else
          for (int k = 0; k < N; k++)
            if (off < 0 && m_has[(m_rp + k) % N] && !m_filt((m_rp + k) % N)) off = (m_rp + k) % N;
      end
      ev = (off >= 0);
      if (ev) exp_q.push_back(m_hm[off][RW-1 -: VALW]);

      @(negedge FXCLK);
      chk("rnd_job_ready", 64'(job_ready), 64'(ejr));
      chk("rnd_res_valid", 64'(res_valid), 64'(ev));
      chk("rnd_busy_cnt", 64'(busy_cnt), 64'(N - nfree));
      chk("rnd_all_idle", 64'(all_idle), 64'(nfree == N));
      chk("rnd_best_len", 64'(best_len), 64'(m_best));
      for (int i = 0; i < N; i++) begin
        chk($sformatf("rnd_eng_reset%0d", i), 64'(eng_reset[i]),
            64'(!(m_busy[i] && m_load[i] == 0 && !m_has[i])));
        chk($sformatf("rnd_fv%0d", i), 64'(eng_firstvalues[i*RW +: RW]), 64'(m_fv[i]));
      end
      if (ev) begin
        chk("rnd_res_engine", 64'(res_engine), 64'(off));
        chk("rnd_res_marks", 64'(res_marks), 64'(m_hm[off]));
        chk("rnd_res_count", 64'(res_count), 64'(m_hc[off]));
        chk("rnd_res_len", 64'(res_marks[RW-1 -: VALW]), 64'(exp_q.pop_front()));
      end

      if (RESET_IN) begin
        m_reset();
      end else if (abort) begin
        for (int i = 0; i < N; i++) begin
          m_busy[i] = 0; m_load[i] = 0; m_has[i] = 0;
        end
        m_offer = -1;
      end else begin
        sel = -1;
        if (ejr && job_valid)
          for (int k = 0; k < N; k++)
            if (sel < 0 && !m_busy[(m_jp + k) % N]) sel = (m_jp + k) % N;
        xfer = ev && res_ready;
        for (int i = 0; i < N; i++) begin
          if (!m_busy[i]) continue;
          if (m_load[i] > 0) m_load[i]--;
          else if (!m_has[i]) begin
            if (eng_done[i]) begin
              if (eng_numresults[i*6 +: 6] == 6'd0) m_busy[i] = 0;
              else begin
                m_has[i] = 1; m_hm[i] = eng_marks[i*RW +: RW]; m_hc[i] = eng_numresults[i*6 +: 6];
              end
            end
          end else if ((xfer && off == i) || m_filt(i)) begin
            m_busy[i] = 0; m_has[i] = 0;
          end
        end
        if (xfer) begin
          if (m_hm[off][RW-1 -: VALW] < m_best) m_best = m_hm[off][RW-1 -: VALW];
          m_rp = (off + 1) % N;
          m_offer = -1;
        end else begin
          m_offer = off;
        end
        if (sel >= 0) begin
          m_busy[sel] = 1; m_load[sel] = RST; m_has[sel] = 0; m_fv[sel] = job_prefix;
          m_jp = (sel + 1) % N;
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
